// File: rtl/xor_gate.sv
// Bitwise XOR with registered result, parity flag and saturating mismatch counter.
// Optional macro XOR_GATE_CNT_EN builds the diff_cnt counter; otherwise diff_cnt is tied to 0.
module xor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic             F_vld,
  output logic             par,
  output logic [CNT_W-1:0] diff_cnt
);

  logic [WIDTH-1:0] diff;

  assign diff = A ^ B;
  assign F    = diff;

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_q   <= '0;
      F_vld <= 1'b0;
    end else if (en) begin
      F_q   <= diff;
      F_vld <= 1'b1;
    end
  end

  assign par = ^F_q;

`ifdef XOR_GATE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts only enabled captures with any differing bit; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en && (|diff) && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign diff_cnt = cnt_q;
`else
  assign diff_cnt = '0;
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Scoreboard bench for xor_gate: an 8-bit instance with a 2-bit counter and a 1-bit instance
// share clk/rst; the driver queues expectations and a monitor compares after each edge.
module tb_xor_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  a8, b8;
  logic        a1, b1;

  logic [7:0]  f8, fq8;
  logic        vld8, par8;
  logic [1:0]  cnt8;
  logic        f1, fq1, vld1, par1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  xor_gate #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .en(en),
    .F(f8), .F_q(fq8), .F_vld(vld8), .par(par8), .diff_cnt(cnt8)
  );

  xor_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .en(en),
    .F(f1), .F_q(fq1), .F_vld(vld1), .par(par1), .diff_cnt(cnt1)
  );

  typedef struct {
    string       name;
    logic [7:0]  f8, fq8;
    logic        vld8, par8;
    logic [1:0]  cnt8;
    logic        f1, fq1, vld1, par1;
    logic [15:0] cnt1;
  } exp_t;

  exp_t sb[$];
  event check_ev;
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state
  logic [7:0]  m_fq8;
  logic        m_vld;
  logic [1:0]  m_cnt8;
  logic        m_fq1;
  logic [15:0] m_cnt1;

  task automatic check(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, req);
    end
  endtask

  // Monitor: compares one queued expectation after each clock edge or mid-cycle probe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or check_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        check(e.name, "F8",    16'(f8),   16'(e.f8));
        check(e.name, "Fq8",   16'(fq8),  16'(e.fq8));
        check(e.name, "vld8",  16'(vld8), 16'(e.vld8));
        check(e.name, "par8",  16'(par8), 16'(e.par8));
        check(e.name, "cnt8",  16'(cnt8), 16'(e.cnt8));
        check(e.name, "F1",    16'(f1),   16'(e.f1));
        check(e.name, "Fq1",   16'(fq1),  16'(e.fq1));
        check(e.name, "vld1",  16'(vld1), 16'(e.vld1));
        check(e.name, "par1",  16'(par1), 16'(e.par1));
        check(e.name, "cnt1",  cnt1,      e.cnt1);
      end
    end
  end

  task automatic push_exp(input string name, input logic [7:0] exp_f);
    exp_t e;
    e.name = name;
    e.f8   = exp_f;
    e.fq8  = m_fq8;
    e.vld8 = m_vld;
    e.par8 = ^m_fq8;
    e.cnt8 = m_cnt8;
    e.f1   = exp_f[0];
    e.fq1  = m_fq1;
    e.vld1 = m_vld;
    e.par1 = m_fq1;
    e.cnt1 = m_cnt1;
    sb.push_back(e);
  endtask

  task automatic model_clear();
    m_fq8  = '0;
    m_vld  = 1'b0;
    m_cnt8 = '0;
    m_fq1  = 1'b0;
    m_cnt1 = '0;
  endtask

  // One vector per cycle: inputs change on the falling edge, checked after the rising edge.
  task automatic step(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic e, input logic r, input logic [7:0] exp_f);
    @(negedge clk);
    rst = r;
    en  = e;
    a8  = a;
    b8  = b;
    a1  = a[0];
    b1  = b[0];
    if (r) begin
      model_clear();
    end else if (e) begin
      m_fq8 = a ^ b;
      m_fq1 = a[0] ^ b[0];
      m_vld = 1'b1;
`ifdef XOR_GATE_CNT_EN
      if ((a ^ b) != 8'h00 && m_cnt8 != 2'd3) m_cnt8 = m_cnt8 + 2'd1;
      if ((a[0] ^ b[0]) && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
`endif
    end
    push_exp(name, exp_f);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;
    a1  = 1'b0;
    b1  = 1'b0;
    model_clear();

    #3;
    push_exp("reset", 8'h00);
    ->check_ev;

    // Enabled vector while reset held: registers stay cleared, F still live
    step("rst_hold", 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF);

    // Truth table with en=0
    step("tt_en0_00", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    step("tt_en0_01", 8'h00, 8'h01, 1'b0, 1'b0, 8'h01);
    step("tt_en0_10", 8'h01, 8'h00, 1'b0, 1'b0, 8'h01);
    step("tt_en0_11", 8'h01, 8'h01, 1'b0, 1'b0, 8'h00);

    // Truth table with en=1
    step("tt_en1_00", 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    step("tt_en1_01", 8'h00, 8'h01, 1'b1, 1'b0, 8'h01);
    step("tt_en1_10", 8'h01, 8'h00, 1'b1, 1'b0, 8'h01);
    step("tt_en1_11", 8'h01, 8'h01, 1'b1, 1'b0, 8'h00);

    // Hold on en=0
    step("cap_10",    8'h01, 8'h00, 1'b1, 1'b0, 8'h01);
    step("hold_11",   8'h01, 8'h01, 1'b0, 1'b0, 8'h00);

    // 8-bit patterns and parity
    step("a5_0f",     8'hA5, 8'h0F, 1'b1, 1'b0, 8'hAA);
    step("01_00",     8'h01, 8'h00, 1'b1, 1'b0, 8'h01);
    step("3c_c3",     8'h3C, 8'hC3, 1'b1, 1'b0, 8'hFF);
    step("a5_0f_b",   8'hA5, 8'h0F, 1'b1, 1'b0, 8'hAA);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_clear();
    push_exp("mid_rst", 8'hAA);
    ->check_ev;
    step("mid_rst_hold", 8'h5A, 8'h0F, 1'b1, 1'b1, 8'h55);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 6; i++)
      step($sformatf("sat_%0d", i), 8'h01, 8'h00, 1'b1, 1'b0, 8'h01);

    step("idle", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_gate.md
Name: xor_gate

Overview:
Bitwise two-input XOR primitive with a registered copy of its result, a parity flag and a saturating mismatch counter. Its combinational output is the plain A^B truth-table function used wherever a gate-level XOR is needed. Its registered outputs let it sit inside clocked datapaths as a compare/difference stage. With WIDTH=1 it is a drop-in single-bit XOR gate.

Parameters:
WIDTH, 1, bit width of A, B, F and F_q
CNT_W, 16, width of the mismatch counter diff_cnt

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
en  input  1  capture enable for registered outputs
F  output  WIDTH  combinational A XOR B
F_q  output  WIDTH  registered A XOR B
F_vld  output  1  F_q holds a value captured since reset
par  output  1  reduction XOR of F_q
diff_cnt  output  CNT_W  count of captures where A != B

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- F = A ^ B bitwise, purely combinational, zero latency.
- F is independent of clk, rst and en; it is valid during reset.
- For WIDTH=1, F follows the truth table: 00->0, 01->1, 10->1, 11->0.
- F is X-free whenever A and B are X-free.
- Reset (rst=1, asynchronous assert, release sampled at the next clk edge):
  - F_q = 0, F_vld = 0, par = 0, diff_cnt = 0.
  - All registered outputs remain held at these values while rst=1.
- Rising clk edge with rst=0 and en=1:
  - F_q <= A ^ B.
  - F_vld <= 1.
  - If (A ^ B) != 0, diff_cnt <= diff_cnt + 1, saturating at 2^CNT_W-1.
- Rising clk edge with rst=0 and en=0: all registers hold their values.
- Latency: F_q reflects the A/B values present at the enabling edge, one cycle after they are presented.
- par = ^F_q, combinational from the register. par = 0 after reset.
- F_vld stays 1 until the next reset.
- Saturation: at all-ones, diff_cnt holds; it does not wrap.
- Reset asserted mid-operation: registered outputs clear immediately, without waiting for a clock edge. F is unaffected.
- en=1 held continuously: F_q updates every cycle.

Optional Feature:
Macro XOR_GATE_CNT_EN.
- Defined: diff_cnt is implemented as specified above.
- Not defined: no counter register is built; diff_cnt is tied to constant 0. All other outputs are unchanged.

Test Plan:
- WIDTH=1, en=0; drive A,B = 00, 01, 10, 11, each held 100 ns -> F = 0, 1, 1, 0. Log F via monitor and dump waveforms. F_q stays 0.
- WIDTH=1, en=1, same sequence, one vector per clk -> F_q = 0, 1, 1, 0, one cycle late. F_vld=1 from the first edge. diff_cnt ends at 2 (macro on) or 0 (macro off).
- WIDTH=8: A=8'hA5, B=8'h0F, en=1 -> F = 8'hAA immediately; F_q = 8'hAA after one edge; par = 0. Then A=8'h01, B=8'h00 -> F_q = 8'h01, par = 1.
- Assert rst between clock edges while F_q=8'hAA and diff_cnt=3 -> F_q, F_vld, par and diff_cnt go to 0 without a clk edge. F still tracks A^B.
- CNT_W=2, macro on, A=1, B=0, en=1 for 6 cycles -> diff_cnt counts 1, 2, 3, then holds at 3.
- en toggling: en=0 on a cycle with A=1, B=1 -> F = 0, but F_q and diff_cnt are unchanged.
